// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1-style UART receiver with a two-flop input synchronizer,
// mid-bit sampling, start-bit glitch rejection and stop-bit framing check.
module uart_rx_core #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_frame_err,
  output logic                 rx_busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  logic                 sync1_q, sync2_q;
  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 rx_frame_err_q, rx_frame_err_d;
  logic                 rx_busy_q, rx_busy_d;

  // Bring the asynchronous line into the clock domain; idle level is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx_in;
      sync2_q <= sync1_q;
    end
  end

  // Next-state and output decode; strobes default low so they last one cycle.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    bit_idx_d      = bit_idx_q;
    shreg_d        = shreg_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    rx_frame_err_d = 1'b0;
    rx_busy_d      = rx_busy_q;
    case (state_q)
      IDLE: begin
        cnt_d     = '0;
        bit_idx_d = '0;
        // An x/z line compares false here, so it cannot start a frame.
        if (sync2_q == 1'b0) begin
          state_d   = START;
          rx_busy_d = 1'b1;
        end
      end
      START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          if (sync2_q == 1'b0) begin
            state_d = DATA;
          end else begin
            // Line went back high before mid start bit: a glitch.
            state_d   = IDLE;
            rx_busy_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shreg_d = {sync2_q, shreg_q[DATA_BITS-1:1]};
          if (bit_idx_q == LAST_IDX) begin
            bit_idx_d = '0;
            state_d   = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          if (sync2_q == 1'b1) begin
            rx_data_d  = shreg_q;
            rx_valid_d = 1'b1;
            rx_busy_d  = 1'b0;
            state_d    = IDLE;
          end else begin
            // Keep busy while the line stays low so a break is one error.
            rx_frame_err_d = 1'b1;
            state_d        = WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_HIGH: begin
        if (sync2_q == 1'b1) begin
          state_d   = IDLE;
          rx_busy_d = 1'b0;
        end
      end
      default: begin
        state_d   = IDLE;
        rx_busy_d = 1'b0;
      end
    endcase
  end

  // Receiver state and registered outputs; reset discards any partial frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      bit_idx_q      <= '0;
      shreg_q        <= '0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      rx_frame_err_q <= 1'b0;
      rx_busy_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      bit_idx_q      <= bit_idx_d;
      shreg_q        <= shreg_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      rx_frame_err_q <= rx_frame_err_d;
      rx_busy_q      <= rx_busy_d;
    end
  end

  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign rx_frame_err = rx_frame_err_q;
  assign rx_busy      = rx_busy_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core at the default 16 clk/bit, 8 data bits.
module tb_uart_rx_core;

  localparam int C = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_in;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       rx_busy;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  int busy_cnt = 0;
  int both_cnt = 0;
  int last_vcyc = 0;
  int prev_vcyc = 0;
  int last_ecyc = 0;
  logic [7:0] last_vdata = 8'h00;
  logic [7:0] prev_vdata = 8'h00;
  int frame_start_cyc = 0;

  int v0, e0, b0;

  uart_rx_core #(.CLKS_PER_BIT(C), .DATA_BITS(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_in       (rx_in),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_frame_err(rx_frame_err),
    .rx_busy     (rx_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      valid_cnt  <= valid_cnt + 1;
      prev_vcyc  <= last_vcyc;
      last_vcyc  <= cyc;
      prev_vdata <= last_vdata;
      last_vdata <= rx_data;
    end
    if (rx_frame_err === 1'b1) begin
      err_cnt   <= err_cnt + 1;
      last_ecyc <= cyc;
    end
    if (rx_busy === 1'b1) busy_cnt <= busy_cnt + 1;
    if (rx_valid === 1'b1 && rx_frame_err === 1'b1) both_cnt <= both_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start bit, LSB-first data, then the given stop level held one bit time.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    frame_start_cyc = cyc;
    rx_in = 1'b0;
    repeat (C) tick();
    for (int i = 0; i < 8; i++) begin
      rx_in = d[i];
      repeat (C) tick();
    end
    rx_in = stop_bit;
    repeat (C) tick();
  endtask

  initial begin
    rst_n = 1'b1;
    rx_in = 1'b1;
    #2 rst_n = 1'b0;

    // Reset values
    repeat (5) tick();
    check("rst_valid", 32'(rx_valid), 32'h0);
    check("rst_ferr", 32'(rx_frame_err), 32'h0);
    check("rst_busy", 32'(rx_busy), 32'h0);
    check("rst_data", 32'(rx_data), 32'h0);
    rst_n = 1'b1;
    tick();
    check("post_rst_valid", 32'(rx_valid), 32'h0);
    check("post_rst_ferr", 32'(rx_frame_err), 32'h0);
    check("post_rst_busy", 32'(rx_busy), 32'h0);
    check("post_rst_data", 32'(rx_data), 32'h0);
    b0 = busy_cnt;
    repeat (100) tick();
    check("idle_busy_cycles", 32'(busy_cnt - b0), 32'h0);

    // Single frame 0xA5
    v0 = valid_cnt; e0 = err_cnt;
    send_frame(8'hA5, 1'b1);
    repeat (10) tick();
    check("a5_data", 32'(rx_data), 32'hA5);
    check("a5_valid_cycles", 32'(valid_cnt - v0), 32'h1);
    check("a5_valid_at_e154", 32'(last_vcyc - frame_start_cyc), 32'd155);
    check("a5_no_ferr", 32'(err_cnt - e0), 32'h0);
    check("a5_idle_busy", 32'(rx_busy), 32'h0);

    // Glitch of 4 cycles
    v0 = valid_cnt; e0 = err_cnt;
    rx_in = 1'b0;
    repeat (4) tick();
    rx_in = 1'b1;
    repeat (10) tick();
    check("glitch_busy", 32'(rx_busy), 32'h0);
    check("glitch_no_valid", 32'(valid_cnt - v0), 32'h0);
    check("glitch_no_ferr", 32'(err_cnt - e0), 32'h0);
    repeat (10) tick();
    send_frame(8'h3C, 1'b1);
    repeat (10) tick();
    check("3c_data", 32'(rx_data), 32'h3C);
    check("3c_valid_cycles", 32'(valid_cnt - v0), 32'h1);

    // Framing error: 0x81 with low stop bit, then a 40-cycle break
    v0 = valid_cnt; e0 = err_cnt;
    send_frame(8'h81, 1'b0);
    repeat (40) tick();
    check("ferr_cycles", 32'(err_cnt - e0), 32'h1);
    check("ferr_at_e154", 32'(last_ecyc - frame_start_cyc), 32'd155);
    check("ferr_no_valid", 32'(valid_cnt - v0), 32'h0);
    check("ferr_data_kept", 32'(rx_data), 32'h3C);
    check("ferr_busy_in_break", 32'(rx_busy), 32'h1);
    rx_in = 1'b1;
    repeat (20) tick();
    check("ferr_busy_released", 32'(rx_busy), 32'h0);
    check("ferr_no_more_strobes", 32'(valid_cnt - v0 + err_cnt - e0), 32'h1);

    // Back-to-back 0x00 then 0xFF with no idle gap
    v0 = valid_cnt; e0 = err_cnt;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    repeat (10) tick();
    check("b2b_valid_count", 32'(valid_cnt - v0), 32'h2);
    check("b2b_first_data", 32'(prev_vdata), 32'h00);
    check("b2b_second_data", 32'(last_vdata), 32'hFF);
    check("b2b_spacing", 32'(last_vcyc - prev_vcyc), 32'd160);
    check("b2b_second_at_e154", 32'(last_vcyc - frame_start_cyc), 32'd155);
    check("b2b_no_ferr", 32'(err_cnt - e0), 32'h0);

    // Reset during data bit 3 of 0x5A (bits LSB first: 0,1,0,1)
    v0 = valid_cnt; e0 = err_cnt;
    rx_in = 1'b0; repeat (C) tick();
    rx_in = 1'b0; repeat (C) tick();
    rx_in = 1'b1; repeat (C) tick();
    rx_in = 1'b0; repeat (C) tick();
    rx_in = 1'b1; repeat (8) tick();
    check("mid_busy_before_rst", 32'(rx_busy), 32'h1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(rx_busy), 32'h0);
    check("mid_rst_data", 32'(rx_data), 32'h0);
    check("mid_rst_valid", 32'(rx_valid), 32'h0);
    check("mid_rst_ferr", 32'(rx_frame_err), 32'h0);
    rx_in = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (20) tick();
    check("mid_aborted_no_strobe", 32'(valid_cnt - v0 + err_cnt - e0), 32'h0);
    send_frame(8'hC3, 1'b1);
    repeat (10) tick();
    check("c3_data", 32'(rx_data), 32'hC3);
    check("c3_valid_cycles", 32'(valid_cnt - v0), 32'h1);
    check("c3_at_e154", 32'(last_vcyc - frame_start_cyc), 32'd155);

    check("never_both_strobes", 32'(both_cnt), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
